// File: rtl/ula_sequenciador.sv
// ula_sequenciador: multi-byte operation sequencer for the shared 8-bit
// 74181-style ALU (ula_8_bits). One N_BYTES-wide operation is accepted per
// valid/ready handshake and run through the external ALU one byte per cycle,
// LSB first, with the ALU carry chained from byte to byte. The full result
// is then offered on a valid/ready output handshake.
//
// Optional feature (macro ULA_SEQUENCIADOR_ACC_EN): adds input op_use_acc and
// an internal accumulator loaded with each completed result; when op_use_acc
// is set at accept time the accumulator replaces op_a as operand A.

module ula_sequenciador #(
  parameter int N_BYTES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [8*N_BYTES-1:0]   op_a,
  input  logic [8*N_BYTES-1:0]   op_b,
  input  logic [3:0]             op_s,
  input  logic                   op_m,
  input  logic                   op_cin,
`ifdef ULA_SEQUENCIADOR_ACC_EN
  input  logic                   op_use_acc,
`endif
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [8*N_BYTES-1:0]   res_f,
  output logic                   res_cout,
  output logic                   res_eq,
  output logic                   busy,
  output logic [7:0]             alu_a,
  output logic [7:0]             alu_b,
  output logic [3:0]             alu_s,
  output logic                   alu_m,
  output logic                   alu_cin,
  input  logic [7:0]             alu_f,
  input  logic                   alu_cout,
  input  logic                   alu_eq
);

  localparam int W     = 8 * N_BYTES;
  localparam int IDX_W = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BYTES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q,   idx_d;
  logic [W-1:0]     a_q,     a_d;
  logic [W-1:0]     b_q,     b_d;
  logic [3:0]       s_q,     s_d;
  logic             m_q,     m_d;
  logic             carry_q, carry_d;
  logic             eq_q,    eq_d;
  logic [W-1:0]     res_f_q, res_f_d;
`ifdef ULA_SEQUENCIADOR_ACC_EN
  logic [W-1:0]     acc_q,   acc_d;
`endif

  // Bit offset of the byte currently being processed (idx * 8).
  logic [IDX_W+2:0] byte_lsb;
  assign byte_lsb = {idx_q, 3'b000};

  // Next-state logic: accept in IDLE, one byte per cycle in EXEC, hold in DONE.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    m_d     = m_q;
    carry_d = carry_q;
    eq_d    = eq_q;
    res_f_d = res_f_q;
`ifdef ULA_SEQUENCIADOR_ACC_EN
    acc_d   = acc_q;
`endif
    alu_a   = 8'h00;
    alu_b   = 8'h00;
    alu_s   = 4'h0;
    alu_m   = 1'b0;
    alu_cin = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
`ifdef ULA_SEQUENCIADOR_ACC_EN
          a_d = op_use_acc ? acc_q : op_a;
`else
          a_d = op_a;
`endif
          b_d     = op_b;
          s_d     = op_s;
          m_d     = op_m;
          carry_d = op_cin;
          eq_d    = 1'b1;
          idx_d   = '0;
          state_d = EXEC;
        end
      end

      EXEC: begin
        alu_a   = a_q[byte_lsb +: 8];
        alu_b   = b_q[byte_lsb +: 8];
        alu_s   = s_q;
        alu_m   = m_q;
        alu_cin = carry_q;
        res_f_d[byte_lsb +: 8] = alu_f;
        carry_d = alu_cout;
        eq_d    = eq_q & alu_eq;
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
`ifdef ULA_SEQUENCIADOR_ACC_EN
          acc_d   = res_f_q;
`endif
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= 4'h0;
      m_q     <= 1'b0;
      carry_q <= 1'b0;
      eq_q    <= 1'b0;
      res_f_q <= '0;
`ifdef ULA_SEQUENCIADOR_ACC_EN
      acc_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      m_q     <= m_d;
      carry_q <= carry_d;
      eq_q    <= eq_d;
      res_f_q <= res_f_d;
`ifdef ULA_SEQUENCIADOR_ACC_EN
      acc_q   <= acc_d;
`endif
    end
  end

  // Handshake and status outputs; in_ready is forced low while reset is held.
  always_comb begin
    in_ready  = (state_q == IDLE) && !rst;
    out_valid = (state_q == DONE);
    busy      = (state_q == EXEC) || (state_q == DONE);
    res_f     = res_f_q;
    res_cout  = carry_q;
    res_eq    = eq_q;
  end

endmodule
